// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory stage of the 5-stage pipeline, between the EX/MEM and MEM/WB
// registers. It runs the data-memory request/ready handshake, formats store
// strobes and data, aligns and extends load data, and owns the MEM/WB register.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   in_*                    EX/MEM pipeline register contents
//   rd_addr_mem/_write_mem  MEM-stage destination, for the hazard unit
//   mem_stall               freezes PC, IF/ID, ID/EX and EX/MEM this cycle
//   dmem_*                  data-memory request/ready interface
//   rd_addr_wb/_write_wb    MEM/WB destination and write enable
//   wb_data                 MEM/WB result
//   misaligned, bus_err     one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd_addr,
   input  logic            in_rd_write,
   output logic [4:0]      rd_addr_mem,
   output logic            rd_write_mem,
   output logic            mem_stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ready,
   output logic [4:0]      rd_addr_wb,
   output logic            rd_write_wb,
   output logic [XLEN-1:0] wb_data,
   output logic            misaligned,
   output logic            bus_err
);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_t          state_q, state_d;
   logic [7:0]      waitCnt_q, waitCnt_d;
   logic [4:0]      rdAddrWb_q;
   logic            rdWriteWb_q;
   logic [XLEN-1:0] wbData_q;
   logic            misaligned_q;
   logic            busErr_q;

   logic            memOp;
   logic            misal;
   logic            alignedOp;
   logic            complete;
   logic            abort;
   logic [1:0]      offset;
   logic [3:0]      strbRaw;
   logic [7:0]      loadByte;
   logic [15:0]     loadHalf;
   logic [XLEN-1:0] loadData;

   assign offset    = in_alu_result[1:0];
   assign memOp     = in_valid & (in_mem_read | in_mem_write);
   assign alignedOp = memOp & ~misal;

   // Load data is never forwarded out of MEM, so loads do not advertise a
   // write to the hazard unit until they reach WB.
   assign rd_addr_mem  = in_rd_addr;
   assign rd_write_mem = in_valid & in_rd_write & ~in_mem_read;

   assign dmem_we   = in_mem_write;
   assign dmem_addr = {in_alu_result[XLEN-1:2], 2'b00};

   assign rd_addr_wb  = rdAddrWb_q;
   assign rd_write_wb = rdWriteWb_q;
   assign wb_data     = wbData_q;
   assign misaligned  = misaligned_q;
   assign bus_err     = busErr_q;

   // Halfwords must sit on an even address and words on a multiple of four;
   // byte accesses can never be misaligned.
   always_comb begin
      misal = 1'b0;
      case (in_funct3[1:0])
         2'b01:   misal = offset[0];
         2'b10:   misal = (offset != 2'b00);
         default: misal = 1'b0;
      endcase
   end

   // Handshake FSM. A zero-wait access completes straight out of IDLE; only a
   // late ready moves us into WAIT. The EX/MEM inputs are frozen by mem_stall,
   // so address, data and strobes stay stable across the wait without any
   // extra holding registers. When the wait counter reaches TIMEOUT the
   // access is dropped so a dead slave cannot hang the core. Reset overrides
   // the request and stall combinationally so an access caught mid-wait is
   // abandoned in the very cycle reset is seen.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (alignedOp) begin
               dmem_req = 1'b1;
               if (dmem_ready) begin
                  complete = 1'b1;
               end else begin
                  mem_stall = 1'b1;
                  state_d   = ST_WAIT;
                  waitCnt_d = 8'd1;
               end
            end
         end
         ST_WAIT: begin
            if (!alignedOp) begin
               state_d   = ST_IDLE;
               waitCnt_d = 8'd0;
            end else if (dmem_ready) begin
               dmem_req  = 1'b1;
               complete  = 1'b1;
               state_d   = ST_IDLE;
               waitCnt_d = 8'd0;
            end else if (waitCnt_q == TimeoutCnt) begin
               abort     = 1'b1;
               state_d   = ST_IDLE;
               waitCnt_d = 8'd0;
            end else begin
               dmem_req  = 1'b1;
               mem_stall = 1'b1;
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            waitCnt_d = 8'd0;
         end
      endcase
      if (reset) begin
         dmem_req  = 1'b0;
         mem_stall = 1'b0;
      end
   end

   // State register and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         waitCnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Store formatting: the selected lane is replicated across the word so the
   // memory only has to honour the byte strobes. Loads never assert strobes.
   always_comb begin
      strbRaw    = 4'b1111;
      dmem_wdata = in_store_data;
      case (in_funct3[1:0])
         2'b00: begin
            strbRaw    = 4'b0001 << offset;
            dmem_wdata = {(XLEN/8){in_store_data[7:0]}};
         end
         2'b01: begin
            strbRaw    = 4'b0011 << {offset[1], 1'b0};
            dmem_wdata = {(XLEN/16){in_store_data[15:0]}};
         end
         default: begin
            strbRaw    = 4'b1111;
            dmem_wdata = in_store_data;
         end
      endcase
      dmem_wstrb = in_mem_write ? strbRaw : 4'b0000;
   end

   // Load extraction: pick the addressed byte or halfword out of the returned
   // word, then sign-extend (B/H) or zero-extend (BU/HU) it; words pass as-is.
   always_comb begin
      loadByte = dmem_rdata[{offset, 3'b000} +: 8];
      loadHalf = offset[1] ? dmem_rdata[16 +: 16] : dmem_rdata[0 +: 16];
      case (in_funct3)
         3'b000:  loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
         3'b001:  loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
         3'b100:  loadData = {{(XLEN-8){1'b0}}, loadByte};
         3'b101:  loadData = {{(XLEN-16){1'b0}}, loadHalf};
         default: loadData = dmem_rdata;
      endcase
   end

   // MEM/WB register. Non-memory ops pass straight through; memory ops only
   // write back in their completing cycle. Stalled, misaligned and aborted
   // cycles insert a bubble so nothing is written twice or written in error.
   // The error flags are registered so each fault shows as a single pulse
   // alongside the bubble it produced.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdAddrWb_q   <= 5'd0;
         rdWriteWb_q  <= 1'b0;
         wbData_q     <= '0;
         misaligned_q <= 1'b0;
         busErr_q     <= 1'b0;
      end else begin
         misaligned_q <= memOp & misal;
         busErr_q     <= abort;
         if (complete || !memOp) begin
            rdAddrWb_q  <= in_rd_addr;
            rdWriteWb_q <= in_valid & in_rd_write;
            wbData_q    <= (complete && in_mem_read) ? loadData : in_alu_result;
         end else begin
            rdWriteWb_q <= 1'b0;
         end
      end
   end

endmodule
